// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative RV32M divider for the EX stage with stall/flush handshake
module ex_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            sel_rem_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_q;
    logic [CW-1:0]   cnt_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic            is_signed, a_neg, b_neg, div_zero, overflow, special, accept;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic [XLEN:0]   rem_shift, rem_sub, rem_next;
    logic            q_bit;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // Operand decode in IDLE: magnitudes, signs and the two short-circuit cases
    always_comb begin
        is_signed   = ~op_i[0];
        a_neg       = is_signed & dividend_i[XLEN-1];
        b_neg       = is_signed & divisor_i[XLEN-1];
        a_mag       = a_neg ? -dividend_i : dividend_i;
        b_mag       = b_neg ? -divisor_i : divisor_i;
        div_zero    = (divisor_i == '0);
        overflow    = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor_i);
        special     = div_zero | overflow;
        accept      = start_i & ~flush_i;
        // Overflow quotient equals the dividend (most negative value)
        if (div_zero)
            special_res = op_i[1] ? dividend_i : {XLEN{1'b1}};
        else
            special_res = op_i[1] ? {XLEN{1'b0}} : dividend_i;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        rem_next  = q_bit ? rem_sub : rem_shift;
        quo_fix   = q_neg_q ? -quo_q : quo_q;
        rem_fix   = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state, stall request and result pulse
    always_comb begin
        state_d        = state_q;
        stall_req_o    = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_req_o = 1'b1;
                    state_d     = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_req_o = 1'b1;
                if (flush_i)
                    state_d = S_IDLE;
                else if (cnt_q == LAST_ITER)
                    state_d = S_FIX;
            end
            S_FIX: begin
                stall_req_o = 1'b1;
                state_d     = flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                result_valid_o = ~flush_i;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, sign-correct and publish in FIX
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_rem_q <= 1'b0;
            rd_q      <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sel_rem_q <= op_i[1];
                        rd_q      <= rd_addr_i;
                        quo_q     <= a_mag;
                        dvs_q     <= b_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        q_neg_q   <= a_neg ^ b_neg;
                        r_neg_q   <= a_neg;
                        if (special) begin
                            result_o  <= special_res;
                            rd_addr_o <= rd_addr_i;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[XLEN-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    if (!flush_i) begin
                        result_o  <= sel_rem_q ? rem_fix : quo_fix;
                        rd_addr_o <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
